// File: rtl/cycle_sequencer.sv
// Machine-cycle / T-state sequencer: one-hot M1-M6 / T1-T6 strobes, WAIT insertion in T2,
// and bus grant between machine cycles when built with `define SEQ_BUSRQ_EN.
module cycle_sequencer (
  input  logic clk,
  input  logic reset_in,
  input  logic setM1,
  input  logic nextM,
  input  logic wait_in,
  input  logic busrq_in,
  output logic M1,
  output logic M2,
  output logic M3,
  output logic M4,
  output logic M5,
  output logic M6,
  output logic T1,
  output logic T2,
  output logic T3,
  output logic T4,
  output logic T5,
  output logic T6,
  output logic nhold_clk_wait,
  output logic busack
);

  logic [2:0] m_q, m_d;
  logic [2:0] t_q, t_d;
  logic [2:0] tgt;
  logic       granted;
  logic       hold_wait;
  logic       boundary;

`ifdef SEQ_BUSRQ_EN
  logic       grant_q, grant_d;
  logic [2:0] pend_q, pend_d;

  assign granted = grant_q;
`else
  logic unused_busrq;

  assign granted      = 1'b0;
  assign unused_busrq = busrq_in;
`endif

  // T2 is never active while granted, so WAIT cannot freeze a granted bus.
  assign hold_wait      = (t_q == 3'd1) & ~granted & wait_in;
  assign nhold_clk_wait = ~hold_wait;
  assign boundary       = setM1 | nextM;
  assign tgt            = setM1 ? 3'd0 : ((m_q == 3'd5) ? 3'd0 : m_q + 3'd1);

  always_comb begin
    m_d = m_q;
    t_d = t_q;
`ifdef SEQ_BUSRQ_EN
    grant_d = grant_q;
    pend_d  = pend_q;
`endif
    if (granted) begin
`ifdef SEQ_BUSRQ_EN
      if (!busrq_in) begin
        grant_d = 1'b0;
        m_d     = pend_q;
        t_d     = 3'd0;
      end
`endif
    end else if (hold_wait) begin
      m_d = m_q;
      t_d = t_q;
    end else if (boundary) begin
`ifdef SEQ_BUSRQ_EN
      // Bus request is only honoured here, at a machine-cycle boundary.
      if (busrq_in) begin
        pend_d  = tgt;
        grant_d = 1'b1;
      end else begin
        m_d = tgt;
        t_d = 3'd0;
      end
`else
      m_d = tgt;
      t_d = 3'd0;
`endif
    end else if (t_q != 3'd5) begin
      t_d = t_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      m_q <= 3'd0;
      t_q <= 3'd0;
`ifdef SEQ_BUSRQ_EN
      grant_q <= 1'b0;
      pend_q  <= 3'd0;
`endif
    end else begin
      m_q <= m_d;
      t_q <= t_d;
`ifdef SEQ_BUSRQ_EN
      grant_q <= grant_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign M1 = (m_q == 3'd0) & ~granted;
  assign M2 = (m_q == 3'd1) & ~granted;
  assign M3 = (m_q == 3'd2) & ~granted;
  assign M4 = (m_q == 3'd3) & ~granted;
  assign M5 = (m_q == 3'd4) & ~granted;
  assign M6 = (m_q == 3'd5) & ~granted;
  assign T1 = (t_q == 3'd0) & ~granted;
  assign T2 = (t_q == 3'd1) & ~granted;
  assign T3 = (t_q == 3'd2) & ~granted;
  assign T4 = (t_q == 3'd3) & ~granted;
  assign T5 = (t_q == 3'd4) & ~granted;
  assign T6 = (t_q == 3'd5) & ~granted;
  assign busack = granted;

endmodule
